// File: rtl/mem_arbiter.sv
// Two-port line arbiter: shares one physical-memory port between the I-cache and
// D-cache miss paths, one transaction at a time, alternating grants on ties.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;  // 0 = I, 1 = D
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   wdata_q, wdata_d;
  logic                write_q, write_d;

  logic i_req, d_req, grant_i, grant_d, serving;

  assign i_req = i_read;
  assign d_req = d_read | d_write;
  // On a tie the port that did not win last time goes next.
  assign grant_i = i_req & (~d_req | last_grant_q);
  assign grant_d = d_req & ~grant_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its peers; blocking here would create ordering bugs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      addr_q       <= '0;
      wdata_q      <= '0;
      write_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      write_q      <= write_d;
    end
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    write_d      = write_q;
    unique case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d      = SERVE_I;
          last_grant_d = 1'b0;
          addr_d       = i_address;
          wdata_d      = '0;
          write_d      = 1'b0;
        end else if (grant_d) begin
          state_d      = SERVE_D;
          last_grant_d = 1'b1;
          addr_d       = d_address;
          wdata_d      = d_wdata;
          write_d      = d_write;  // write wins when read and write are both high
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign serving      = (state_q == SERVE_I) || (state_q == SERVE_D);
  assign pmem_read    = serving & ~write_q;
  assign pmem_write   = serving & write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;

  assign i_resp  = (state_q == SERVE_I) & pmem_resp;
  assign d_resp  = (state_q == SERVE_D) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: expected transactions are queued as requests
// are raised and checked against the pmem port as the arbiter issues them.
module tb_mem_arbiter;

  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_read, d_read, d_write, pmem_resp;
  logic [ADDR_W-1:0] i_address, d_address;
  logic [LINE_W-1:0] d_wdata, pmem_rdata;
  logic [LINE_W-1:0] i_rdata, d_rdata, pmem_wdata;
  logic              i_resp, d_resp, pmem_read, pmem_write;
  logic [ADDR_W-1:0] pmem_address;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit                port;  // 0 = I, 1 = D
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
  } txn_t;

  txn_t sb[$];

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  function automatic txn_t mk(bit port, bit wr, logic [ADDR_W-1:0] addr,
                              logic [LINE_W-1:0] wdata, logic [LINE_W-1:0] rdata);
    txn_t t;
    t.port = port; t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    return t;
  endfunction

  // Memory model: waits for the next strobe, checks it against the queue head,
  // holds for lat cycles, pulses pmem_resp, then checks the IDLE gap.
  task automatic serve(input int lat, input bit chg_addr, input int exp_wait);
    txn_t e;
    int   w;
    bit   seen;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: no expected transaction queued");
      return;
    end
    e = sb.pop_front();
    seen = 0;
    w = 0;
    while (!seen && w < 20) begin
      @(negedge clk); #1;
      w++;
      if (pmem_read | pmem_write) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL strobe_timeout: no pmem strobe within %0d cycles", w);
      return;
    end
    if (exp_wait > 0) begin
      checks++;
      if (w != exp_wait) begin
        errors++;
        $display("FAIL grant_latency: got %0d cycles, want %0d", w, exp_wait);
      end
    end
    if (chg_addr) i_address = 16'hFFFE;
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) begin
        @(negedge clk); #1;
      end
      checks++;
      if ({pmem_read, pmem_write} !== {~e.wr, e.wr} || pmem_address !== e.addr) begin
        errors++;
        $display("FAIL op_addr(cyc %0d): rd=%b wr=%b addr=%h, want rd=%b wr=%b addr=%h",
                 k, pmem_read, pmem_write, pmem_address, ~e.wr, e.wr, e.addr);
      end
      if (e.wr) begin
        checks++;
        if (pmem_wdata !== e.wdata) begin
          errors++;
          $display("FAIL wdata(cyc %0d): got %h want %h", k, pmem_wdata, e.wdata);
        end
      end
      checks++;
      if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
        errors++;
        $display("FAIL early_resp(cyc %0d): i_resp=%b d_resp=%b, want 0 0", k, i_resp, d_resp);
      end
    end
    @(negedge clk);
    pmem_resp  = 1'b1;
    pmem_rdata = e.rdata;
    #1;
    checks++;
    if (i_resp !== ~e.port || d_resp !== e.port) begin
      errors++;
      $display("FAIL resp_route: i_resp=%b d_resp=%b, want %b %b", i_resp, d_resp, ~e.port, e.port);
    end
    checks++;
    if ((e.port ? d_rdata : i_rdata) !== e.rdata) begin
      errors++;
      $display("FAIL rdata: got %h want %h", e.port ? d_rdata : i_rdata, e.rdata);
    end
    @(negedge clk);
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    #1;
    checks++;
    if (pmem_read || pmem_write || i_resp || d_resp) begin
      errors++;
      $display("FAIL idle_gap: rd=%b wr=%b i_resp=%b d_resp=%b, want all 0",
               pmem_read, pmem_write, i_resp, d_resp);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    i_read = 1'b1; i_address = 16'h0040;
    d_write = 1'b1; d_read = 1'b0; d_address = 16'h0800; d_wdata = {8{16'hBEEF}};
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      checks++;
      if (pmem_read || pmem_write || i_resp || d_resp || pmem_address !== '0 || pmem_wdata !== '0) begin
        errors++;
        $display("FAIL reset_hold(cyc %0d): rd=%b wr=%b ir=%b dr=%b addr=%h, want all 0",
                 c, pmem_read, pmem_write, i_resp, d_resp, pmem_address);
      end
    end
    rst_n = 1'b1;
    sb.push_back(mk(1'b0, 1'b0, 16'h0040, '0, {8{16'h1111}}));
    sb.push_back(mk(1'b1, 1'b1, 16'h0800, {8{16'hBEEF}}, '0));
    serve(1, 1'b0, 1);
    i_read = 1'b0;
    serve(1, 1'b0, 1);
    d_write = 1'b0;
  endtask

  task automatic test_single_i_read;
    @(negedge clk);
    i_read = 1'b1; i_address = 16'h0040;
    sb.push_back(mk(1'b0, 1'b0, 16'h0040, '0, {16{8'hA5}}));
    serve(3, 1'b0, 1);
    i_read = 1'b0;
  endtask

  task automatic test_d_writeback;
    @(negedge clk);
    d_write = 1'b1; d_address = 16'h1230;
    d_wdata = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    sb.push_back(mk(1'b1, 1'b1, 16'h1230, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, '0));
    serve(2, 1'b0, 1);
    // read and write together is a write
    d_read = 1'b1; d_address = 16'h2000; d_wdata = {4{32'hCAFE_F00D}};
    sb.push_back(mk(1'b1, 1'b1, 16'h2000, {4{32'hCAFE_F00D}}, '0));
    serve(1, 1'b0, 1);
    d_read = 1'b0; d_write = 1'b0;
  endtask

  task automatic test_tie_alternation;
    @(negedge clk);
    i_read = 1'b1; i_address = 16'h0100;
    d_read = 1'b1; d_address = 16'h0200;
    for (int r = 0; r < 2; r++) begin
      sb.push_back(mk(1'b0, 1'b0, 16'h0100, '0, {4{32'h1000_0000 + r}}));
      sb.push_back(mk(1'b1, 1'b0, 16'h0200, '0, {4{32'h2000_0000 + r}}));
    end
    for (int t = 0; t < 4; t++) serve(1, 1'b0, 1);
    i_read = 1'b0; d_read = 1'b0;
  endtask

  task automatic test_input_change;
    @(negedge clk);
    i_read = 1'b1; i_address = 16'h0300;
    sb.push_back(mk(1'b0, 1'b0, 16'h0300, '0, {8{16'h7E7E}}));
    serve(3, 1'b1, 1);
    i_read = 1'b0;
  endtask

  task automatic test_reset_mid_txn;
    int  w;
    bit  seen;
    @(negedge clk);
    d_read = 1'b1; d_address = 16'h0440;
    seen = 0; w = 0;
    while (!seen && w < 20) begin
      @(negedge clk); #1;
      w++;
      if (pmem_read) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL mid_reset_start: no read strobe within %0d cycles", w);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; d_read = 1'b0;
    #1;
    checks++;
    if (pmem_read || pmem_write || pmem_address !== '0) begin
      errors++;
      $display("FAIL mid_reset_strobe: rd=%b wr=%b addr=%h, want 0 0 0", pmem_read, pmem_write, pmem_address);
    end
    @(negedge clk);
    pmem_resp = 1'b1; pmem_rdata = {8{16'hDEAD}};
    #1;
    checks++;
    if (d_resp || i_resp) begin
      errors++;
      $display("FAIL stale_resp: i_resp=%b d_resp=%b, want 0 0", i_resp, d_resp);
    end
    @(negedge clk);
    pmem_resp = 1'b0; pmem_rdata = '0;
    #1;
    checks++;
    if (pmem_read || pmem_write) begin
      errors++;
      $display("FAIL post_reset_idle: rd=%b wr=%b, want 0 0", pmem_read, pmem_write);
    end
  endtask

  initial begin
    pmem_resp = 1'b0; pmem_rdata = '0;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_wdata = '0;
    test_reset();
    test_single_i_read();
    test_d_writeback();
    test_tie_alternation();
    test_input_change();
    test_reset_mid_txn();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d entries, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one physical-memory line port between the instruction-cache miss path and the data-cache miss path of the five-stage LC-3b pipeline.
- Sits below the split L1 caches (port a = fetch, port b = memory stage) and above physical memory or L2.
- Grants one transaction at a time and registers the address, write data and operation at grant.
- When both requesters are pending, the grant alternates between them.

Parameters:
- ADDR_W, 16, byte address width.
- LINE_W, 128, cache line width in bits.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- i_read  in  1  icache line read request; level, held until i_resp.
- i_address  in  ADDR_W  icache line address.
- i_rdata  out  LINE_W  line returned to icache.
- i_resp  out  1  one-cycle completion pulse to icache.
- d_read  in  1  dcache line read request; level, held until d_resp.
- d_write  in  1  dcache line write-back request; level, held until d_resp.
- d_address  in  ADDR_W  dcache line address.
- d_wdata  in  LINE_W  dcache write-back line.
- d_rdata  out  LINE_W  line returned to dcache.
- d_resp  out  1  one-cycle completion pulse to dcache.
- pmem_read  out  1  physical-memory read strobe.
- pmem_write  out  1  physical-memory write strobe.
- pmem_address  out  ADDR_W  physical-memory address (registered).
- pmem_wdata  out  LINE_W  physical-memory write data (registered).
- pmem_rdata  in  LINE_W  physical-memory read data.
- pmem_resp  in  1  physical-memory completion; valid in the cycle it is asserted.

Behaviour:
- States: IDLE, SERVE_I, SERVE_D. Registers: state, last_grant (0=I, 1=D), addr_q, wdata_q, write_q.
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, last_grant=1 (so I wins the first tie), addr_q=0, wdata_q=0, write_q=0.
  - All outputs are 0 in the following cycle.
- Reset mid-transaction aborts it. A pmem_resp arriving after reset is ignored, and no i_resp/d_resp is produced for the aborted request.
- Request decoding: i_req = i_read; d_req = d_read | d_write. If d_read and d_write are both high, the request is treated as a write.
- IDLE:
  - Only i_req -> grant I. Only d_req -> grant D.
  - Both -> grant the port that is not last_grant.
  - Neither -> stay in IDLE.
  - On grant: latch address, wdata and write_q (write_q=0 for I), set last_grant, go to SERVE_x.
  - pmem_read=pmem_write=0 while in IDLE.
- SERVE_x:
  - pmem_read = ~write_q, pmem_write = write_q, pmem_address = addr_q, pmem_wdata = wdata_q.
  - The registered values are held for the whole transaction. Requester inputs are not re-sampled.
- Completion:
  - In SERVE_I, i_resp = pmem_resp (combinational). In SERVE_D, d_resp = pmem_resp.
  - Read data passes through combinationally: i_rdata = pmem_rdata and d_rdata = pmem_rdata at all times. Data is only meaningful when resp is high.
  - On pmem_resp the next state is IDLE.
- The non-granted port never sees a resp pulse.
- Latency:
  - A request first visible in IDLE at edge t drives pmem strobes in the cycle after t.
  - The requester sees its resp in the same cycle as pmem_resp.
  - The minimum gap between back-to-back transactions is one IDLE cycle, in which the pmem strobes are low.
- Requester contract: deassert the request in the cycle after resp. A request still high in IDLE is treated as a new transaction.
- Fairness: the alternation guarantees a pending requester waits at most one foreign transaction.
- Strobes are never asserted outside SERVE states. pmem_read and pmem_write are never both 1.

Test Plan:
- Reset hold:
  - Stimulus: assert rst_n=0 for 2 cycles with i_read=d_write=1.
  - Required: pmem_read=pmem_write=i_resp=d_resp=0 throughout; after release, the first grant goes to I.
- Single I read:
  - Stimulus: i_read=1, i_address=0x0040; pmem_resp pulsed 3 cycles after pmem_read rises, with pmem_rdata=128'hA5...A5.
  - Required: pmem_address=0x0040, pmem_read=1 for exactly those cycles; i_resp=1 for one cycle with i_rdata=A5...A5; d_resp stays 0.
- D write-back:
  - Stimulus: d_write=1, d_address=0x1230, d_wdata=128'h0123...CDEF.
  - Required: pmem_write=1, pmem_read=0, pmem_wdata=0123...CDEF, stable until pmem_resp; then d_resp=1 for one cycle.
- Tie alternation:
  - Stimulus: i_read and d_read high together, each re-requested immediately after its resp.
  - Required: grant order I, D, I, D; one IDLE cycle between transactions; each resp goes only to the granted port.
- Input change mid-transaction:
  - Stimulus: after the I grant, change i_address to 0xFFFE.
  - Required: pmem_address stays at the latched value until pmem_resp.
- Reset mid-transaction:
  - Stimulus: drop rst_n during SERVE_D, then pulse pmem_resp one cycle after reset.
  - Required: strobes are 0 the cycle after reset, and no d_resp is generated.
